// File: rtl/aes_inv_cipher_ctrl_pkg.sv
// Shared definitions for the AES inverse-cipher controller.
//   - round counts for the three AES key sizes and the block width
//   - FSM state encoding
//   - GF(2^8) helpers used by the combinational inverse round
package aes_inv_cipher_ctrl_pkg;

    localparam int AES_NR_128 = 10;
    localparam int AES_NR_192 = 12;
    localparam int AES_NR_256 = 14;
    localparam int AES_BLK_W  = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = gf_xtime(p);
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse; it also maps 0 to 0, which is
    // exactly what the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    // Inverse affine transform followed by field inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    // InvMixColumns circulant row: 0e 0b 0d 09, rotated by row index.
    function automatic logic [7:0] mix_coef(input int i);
        case (i & 3)
            0:       return 8'h0e;
            1:       return 8'h0b;
            2:       return 8'h0d;
            default: return 8'h09;
        endcase
    endfunction

endpackage

// File: rtl/aes_inv_cipher_ctrl_round.sv
// One combinational AES inverse round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when last=1)
// Ports:
//   st_in  [127:0] state in, byte 0 in [127:120], column-major (byte = 4*col + row)
//   rk     [127:0] round key
//   last           1 = final round, InvMixColumns bypassed
//   st_out [127:0] state out
module aes_inv_cipher_ctrl_round
    import aes_inv_cipher_ctrl_pkg::*;
(
    input  logic [AES_BLK_W-1:0] st_in,
    input  logic [AES_BLK_W-1:0] rk,
    input  logic                 last,
    output logic [AES_BLK_W-1:0] st_out
);

    logic [7:0] ak [16];
    logic [7:0] mc;

    always_comb begin
        mc     = 8'h00;
        st_out = '0;
        // Row r is rotated right by r: output (col c,row r) comes from col (c-r) mod 4.
        for (int k = 0; k < 16; k++) begin
            ak[k] = inv_sbox(st_in[127 - 8 * ((((k / 4) - (k % 4)) & 3) * 4 + (k % 4)) -: 8])
                    ^ rk[127 - 8 * k -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                mc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    mc = mc ^ gf_mul(mix_coef(j - r), ak[4 * c + j]);
                end
                st_out[127 - 8 * (4 * c + r) -: 8] = last ? ak[4 * c + r] : mc;
            end
        end
    end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse-cipher controller: one inverse round per clock over a
// shared combinational round, round keys fetched by index from an external store.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     ciphertext handshake, in_data [127:0]
//   rk_idx [RKW-1:0]      round-key index requested this cycle, rk [127:0] same-cycle key
//   out_valid/out_ready   plaintext handshake, out_data [127:0] (registered)
//   busy                  high while a block is in flight or waiting to be taken
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a block; accept XORs in_data with key NR
// ST_ROUND | full inverse round with key rnd, NR-1 cycles
// ST_FINAL | last round (no InvMixColumns) with key 0, loads out_data
// ST_DONE  | out_valid held until out_ready
module aes_inv_cipher_ctrl
    import aes_inv_cipher_ctrl_pkg::*;
#(
    parameter int NR  = AES_NR_128,
    parameter int RKW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_data,
    output logic [RKW-1:0]       rk_idx,
    input  logic [AES_BLK_W-1:0] rk,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_data,
    output logic                 busy
);

    state_t               state;
    state_t               state_nxt;
    logic [RKW-1:0]       rnd;
    logic [AES_BLK_W-1:0] st;
    logic [AES_BLK_W-1:0] rnd_out;
    logic                 last;

    assign last = (state == ST_FINAL);

    aes_inv_cipher_ctrl_round u_round (
        .st_in  (st),
        .rk     (rk),
        .last   (last),
        .st_out (rnd_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rk_idx    = RKW'(NR);
        in_ready  = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = ST_ROUND;
            end
            ST_ROUND: begin
                rk_idx = rnd;
                if (rnd == RKW'(1)) state_nxt = ST_FINAL;
            end
            ST_FINAL: begin
                rk_idx    = '0;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd       <= RKW'(NR);
            st        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        st  <= in_data ^ rk;
                        rnd <= RKW'(NR - 1);
                    end
                end
                ST_ROUND: begin
                    st <= rnd_out;
                    if (rnd != '0) rnd <= rnd - RKW'(1);
                end
                ST_FINAL: begin
                    out_data  <= rnd_out;
                    out_valid <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Bench for aes_inv_cipher_ctrl: an AES-128 and an AES-256 instance, a key store per
// instance, and a forward AES cipher used to produce ciphertext for random plaintext.
module tb_aes_inv_cipher_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         sel;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_data;

    logic         a_in_ready, a_out_valid, a_busy;
    logic [3:0]   a_rk_idx;
    logic [127:0] a_rk, a_out_data;
    logic         b_in_ready, b_out_valid, b_busy;
    logic [3:0]   b_rk_idx;
    logic [127:0] b_rk, b_out_data;

    logic [127:0] rk10 [16];
    logic [127:0] rk14 [16];
    logic [127:0] kx   [16];
    logic [7:0]   sbox_t [256];

    assign a_rk = rk10[a_rk_idx];
    assign b_rk = rk14[b_rk_idx];

    aes_inv_cipher_ctrl #(.NR(10), .RKW(4)) dut10 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & ~sel), .in_ready(a_in_ready), .in_data(in_data),
        .rk_idx(a_rk_idx), .rk(a_rk),
        .out_valid(a_out_valid), .out_ready(out_ready & ~sel), .out_data(a_out_data),
        .busy(a_busy)
    );

    aes_inv_cipher_ctrl #(.NR(14), .RKW(4)) dut14 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & sel), .in_ready(b_in_ready), .in_data(in_data),
        .rk_idx(b_rk_idx), .rk(b_rk),
        .out_valid(b_out_valid), .out_ready(out_ready & sel), .out_data(b_out_data),
        .busy(b_busy)
    );

    logic         o_in_ready, o_out_valid, o_busy;
    logic [3:0]   o_rk_idx;
    logic [127:0] o_out_data;
    assign o_in_ready = sel ? b_in_ready  : a_in_ready;
    assign o_out_valid = sel ? b_out_valid : a_out_valid;
    assign o_busy     = sel ? b_busy      : a_busy;
    assign o_rk_idx   = sel ? b_rk_idx    : a_rk_idx;
    assign o_out_data = sel ? b_out_data  : a_out_data;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model: forward AES ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // key is left-aligned in 256 bits; result lands in kx[0..nr]
    task automatic expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r < 16; r++) kx[r] = '0;
        for (int r = 0; r <= nr; r++) kx[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    function automatic logic [127:0] rkey(input int r, input int nr);
        return (nr == 14) ? rk14[r] : rk10[r];
    endfunction

    function automatic logic [127:0] enc(input logic [127:0] pt, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] v;
        v = pt ^ rkey(0, nr);
        for (int r = 1; r <= nr; r++) begin
            for (int k = 0; k < 16; k++) s[k] = sbox_t[v[127 - 8 * k -: 8]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) t[4 * c + w] = s[4 * ((c + w) % 4) + w];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c+0] = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
                    s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
                end
                for (int k = 0; k < 16; k++) t[k] = s[k];
            end
            for (int k = 0; k < 16; k++) v[127 - 8 * k -: 8] = t[k];
            v = v ^ rkey(r, nr);
        end
        return v;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus ----------------
    task automatic run_block(input logic [127:0] ct, input logic [127:0] pt,
                             input int hold, input bit trace, input bit noise);
        int           nr, lat, wn;
        logic [3:0]   q [$];
        logic [127:0] held;
        nr = sel ? 14 : 10;
        @(negedge clk);
        in_data  = ct;
        in_valid = 1'b1;
        wn = 0;
        while (!o_in_ready && wn < 50) begin
            @(negedge clk);
            wn++;
        end
        if (!o_in_ready) begin
            chk("in_ready_timeout", 128'(o_in_ready), 128'(1));
            in_valid = 1'b0;
            return;
        end
        if (trace) chk("rk_idx_idle", 128'(o_rk_idx), 128'(nr));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = rand128();
        lat = 1;
        while (!o_out_valid && lat < 64) begin
            if (trace) q.push_back(o_rk_idx);
            if (noise) begin
                in_valid  = 1'($urandom % 2);
                in_data   = rand128();
                out_ready = 1'($urandom % 2);
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (!o_out_valid) begin
            chk("out_valid_timeout", 128'(o_out_valid), 128'(1));
            return;
        end
        chk("latency", 128'(lat), 128'(nr + 1));
        if (trace) begin
            chk("rk_trace_len", 128'(q.size()), 128'(nr));
            for (int i = 0; i < q.size(); i++) chk("rk_trace", 128'(q[i]), 128'(nr - 1 - i));
        end
        chk("out_data", o_out_data, pt);
        held = o_out_data;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", 128'(o_out_valid), 128'(1));
            chk("hold_data", o_out_data, held);
            chk("hold_in_ready", 128'(o_in_ready), 128'(0));
            chk("hold_busy", 128'(o_busy), 128'(1));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_valid", 128'(o_out_valid), 128'(0));
        chk("release_in_ready", 128'(o_in_ready), 128'(1));
        if (trace) chk("rk_idx_back", 128'(o_rk_idx), 128'(nr));
    endtask

    task automatic back_to_back();
        logic [127:0] pts [3];
        logic [127:0] cts [3];
        logic [127:0] got [$];
        int           tm  [$];
        int           idx;
        bit           rdy;
        for (int i = 0; i < 3; i++) begin
            pts[i] = rand128();
            cts[i] = enc(pts[i], 10);
        end
        idx       = 0;
        in_data   = cts[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            rdy = o_in_ready;
            @(posedge clk); #1;
            if (rdy && in_valid) begin
                idx++;
                if (idx < 3) in_data = cts[idx];
                else         in_valid = 1'b0;
            end
            if (o_out_valid) begin
                got.push_back(o_out_data);
                tm.push_back(cyc);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_count", 128'(got.size()), 128'(3));
        for (int i = 0; i < got.size() && i < 3; i++) chk("b2b_data", got[i], pts[i]);
        for (int i = 1; i < tm.size(); i++) chk("b2b_gap", 128'(tm[i] - tm[i - 1]), 128'(12));
    endtask

    task automatic reset_mid_op();
        logic [127:0] pt;
        int           n;
        pt = rand128();
        @(negedge clk);
        in_data  = enc(pt, 10);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (o_rk_idx != 4'd5 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_reach_rnd5", 128'(o_rk_idx), 128'(5));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 128'(o_out_valid), 128'(0));
        chk("rst_in_ready", 128'(o_in_ready), 128'(1));
        chk("rst_busy", 128'(o_busy), 128'(0));
        chk("rst_rk_idx", 128'(o_rk_idx), 128'(10));
        chk("rst_out_data", o_out_data, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            chk("post_rst_no_output", 128'(o_out_valid), 128'(0));
        end
        pt = rand128();
        run_block(enc(pt, 10), pt, 1, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pt;
        rst_n     = 1'b0;
        sel       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        build_sbox();
        expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        for (int i = 0; i < 16; i++) rk10[i] = kx[i];
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
        for (int i = 0; i < 16; i++) rk14[i] = kx[i];

        #3;
        chk("reset_in_ready", 128'(a_in_ready), 128'(1));
        chk("reset_rk_idx", 128'(a_rk_idx), 128'(10));
        chk("reset_rk_idx14", 128'(b_rk_idx), 128'(14));
        chk("reset_out_valid", 128'(a_out_valid), 128'(0));
        chk("reset_busy", 128'(a_busy), 128'(0));
        chk("reset_out_data", a_out_data, 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h00112233445566778899aabbccddeeff, 5, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            pt = rand128();
            run_block(enc(pt, 10), pt, $urandom_range(0, 3), 1'b0, 1'b1);
        end

        expand({rand128(), 128'h0}, 4, 10);
        for (int i = 0; i < 16; i++) rk10[i] = kx[i];
        for (int i = 0; i < 4; i++) begin
            pt = rand128();
            run_block(enc(pt, 10), pt, $urandom_range(0, 2), 1'b0, 1'b1);
        end
        back_to_back();
        reset_mid_op();

        sel = 1'b1;
        run_block(128'h8ea2b7ca516745bfeafc49904b496089,
                  128'h00112233445566778899aabbccddeeff, 2, 1'b1, 1'b0);
        expand({rand128(), rand128()}, 8, 14);
        for (int i = 0; i < 16; i++) rk14[i] = kx[i];
        for (int i = 0; i < 3; i++) begin
            pt = rand128();
            run_block(enc(pt, 14), pt, $urandom_range(0, 2), 1'b0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
